nv_nvdla_cmac_core_macn: RTL and testbench

NV_NVDLA_CMAC_CORE_MACN -- requirements
Module: nv_nvdla_cmac_core_macn

---
 rtl/nv_nvdla_cmac_core_macn.sv | 188 ++++++++++++++++++
 tb/tb_nv_nvdla_cmac_core_macn.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_cmac_core_macn.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cmac_core_macn
//
// One MAC cell of the convolution core: an ATOMC-lane signed dot product per
// atom, summed and accumulated over a configurable number of atoms (a group).
// At the end of each group it emits the saturated accumulation as a one-cycle
// pulse.
//
// Pipeline:  stage 1 = lane products, stage 2 = adder tree, stage 3 = accumulator
//            and output registers. The last atom of a group accepted in cycle T
//            produces mac_out_pvld in cycle T+3. The pipeline sustains one atom
//            per cycle.
//
// Ports
//   nvdla_core_clk   core clock, rising edge
//   nvdla_core_rstn  synchronous active-low reset
//   cfg_reg_en       config strobe: latches cfg_acc_len and flushes the datapath
//   cfg_acc_len      atoms per group (0 behaves as 1)
//   dat_actv_*       feature atom: packed lanes, per-lane non-zero mask, valid
//   wt_actv_*        weight atom: same packing
//   mac_out_data     signed accumulated result (held between pulses)
//   mac_out_pvld     one-cycle result-valid pulse
//   mac_out_sat      saturation seen anywhere in the group (held with data)
// ---------------------------------------------------------------------------
module nv_nvdla_cmac_core_macn #(
    parameter int ATOMC     = 8,
    parameter int BPE       = 8,
    parameter int ACC_GUARD = 4,
    localparam int SUM_W    = 2*BPE + $clog2(ATOMC),
    localparam int ACC_W    = SUM_W + ACC_GUARD
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic                   cfg_reg_en,
    input  logic [7:0]             cfg_acc_len,
    input  logic [ATOMC*BPE-1:0]   dat_actv_data,
    input  logic [ATOMC-1:0]       dat_actv_nz,
    input  logic                   dat_actv_pvld,
    input  logic [ATOMC*BPE-1:0]   wt_actv_data,
    input  logic [ATOMC-1:0]       wt_actv_nz,
    input  logic                   wt_actv_pvld,
    output logic [ACC_W-1:0]       mac_out_data,
    output logic                   mac_out_pvld,
    output logic                   mac_out_sat
);

    localparam int PROD_W = 2*BPE;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // A config strobe takes priority: an atom presented alongside it is dropped.
    logic atom_accept;
    assign atom_accept = dat_actv_pvld & wt_actv_pvld & ~cfg_reg_en;

    // -----------------------------------------------------------------------
    // Stage 1: per-lane products
    // -----------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_next [ATOMC];
    logic signed [PROD_W-1:0] prod_reg  [ATOMC];

    genvar gi;
    generate
        for (gi = 0; gi < ATOMC; gi++) begin : g_lane
            logic signed [BPE-1:0]    dat_op;
            logic signed [BPE-1:0]    wt_op;
            logic signed [PROD_W-1:0] lane_prod;
            assign dat_op = dat_actv_data[gi*BPE +: BPE];
            assign wt_op  = wt_actv_data[gi*BPE +: BPE];
            // Operands are sign-extended first so the low PROD_W bits of the
            // product are the exact signed result.
            assign lane_prod = PROD_W'(dat_op) * PROD_W'(wt_op);
            // A zero in either mask means the lane carries no contribution.
            assign prod_next[gi] = (dat_actv_nz[gi] & wt_actv_nz[gi]) ? lane_prod : '0;
        end
    endgenerate

    // Data-only registers: validity travels in the stage valid bits, so these
    // need no reset and load only when an atom is taken.
    always_ff @(posedge nvdla_core_clk) begin
        if (atom_accept) begin
            for (int i = 0; i < ATOMC; i++) begin
                prod_reg[i] <= prod_next[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: adder tree (SUM_W is wide enough that the sum is exact)
    // -----------------------------------------------------------------------
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] sum_reg;
    logic                    s1_vld_reg;
    logic                    s2_vld_reg;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < ATOMC; i++) begin
            sum_next = sum_next + SUM_W'(prod_reg[i]);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (s1_vld_reg) begin
            sum_reg <= sum_next;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: saturating accumulator, group counter, output registers
    // -----------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_reg;
    logic [7:0]              acc_len_reg;
    logic [7:0]              grp_cnt_reg;
    logic                    sticky_reg;
    logic [ACC_W-1:0]        out_data_reg;
    logic                    out_pvld_reg;
    logic                    out_sat_reg;

    logic signed [ACC_W:0]   acc_base;
    logic signed [ACC_W:0]   acc_total;
    logic                    acc_ovf;
    logic [ACC_W-1:0]        acc_next;
    logic                    sticky_next;
    logic                    grp_last;

    always_comb begin
        // The first atom of a group starts from zero instead of the old value.
        acc_base = '0;
        if (grp_cnt_reg != 8'd0) begin
            acc_base = {acc_reg[ACC_W-1], acc_reg};
        end
        // One extra bit of headroom: the top two bits disagree exactly when
        // the true sum is outside the ACC_W range.
        acc_total = acc_base + (ACC_W+1)'(sum_reg);
        acc_ovf   = acc_total[ACC_W] ^ acc_total[ACC_W-1];
        acc_next  = acc_total[ACC_W-1:0];
        if (acc_ovf) begin
            acc_next = acc_total[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        sticky_next = sticky_reg | acc_ovf;
        grp_last    = (grp_cnt_reg == acc_len_reg - 8'd1);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            s1_vld_reg   <= 1'b0;
            s2_vld_reg   <= 1'b0;
            acc_reg      <= '0;
            acc_len_reg  <= 8'd1;
            grp_cnt_reg  <= 8'd0;
            sticky_reg   <= 1'b0;
            out_data_reg <= '0;
            out_pvld_reg <= 1'b0;
            out_sat_reg  <= 1'b0;
        end else if (cfg_reg_en) begin
            // Flush everything in flight; the last published result is kept.
            acc_len_reg  <= (cfg_acc_len == 8'd0) ? 8'd1 : cfg_acc_len;
            s1_vld_reg   <= 1'b0;
            s2_vld_reg   <= 1'b0;
            acc_reg      <= '0;
            grp_cnt_reg  <= 8'd0;
            sticky_reg   <= 1'b0;
            out_pvld_reg <= 1'b0;
        end else begin
            s1_vld_reg   <= atom_accept;
            s2_vld_reg   <= s1_vld_reg;
            out_pvld_reg <= 1'b0;
            if (s2_vld_reg) begin
                acc_reg <= acc_next;
                if (grp_last) begin
                    grp_cnt_reg  <= 8'd0;
                    sticky_reg   <= 1'b0;
                    out_data_reg <= acc_next;
                    out_sat_reg  <= sticky_next;
                    out_pvld_reg <= 1'b1;
                end else begin
                    grp_cnt_reg  <= grp_cnt_reg + 8'd1;
                    sticky_reg   <= sticky_next;
                end
            end
        end
    end

    assign mac_out_data = out_data_reg;
    assign mac_out_pvld = out_pvld_reg;
    assign mac_out_sat  = out_sat_reg;

endmodule

// File: tb/tb_nv_nvdla_cmac_core_macn.sv
// ---------------------------------------------------------------------------
// tb_nv_nvdla_cmac_core_macn
//
// Two instances share all stimulus: u_g4 (ACC_GUARD=4, 23-bit result) and
// u_g0 (ACC_GUARD=0, 19-bit result) so both wide and saturating behaviour are
// covered by the same vectors.
//
// The reference model works per atom at the moment it is driven: dot product
// with plain integer arithmetic, clamped group accumulation, and a list of
// expected pulses with the cycle they are due. A negedge compare process checks
// every cycle: the expected pulse when one is due, otherwise no pulse and held
// outputs. Literal checks after each scenario pin the model to hand values.
// ---------------------------------------------------------------------------
module tb_nv_nvdla_cmac_core_macn;

    localparam int ATOMC = 8;
    localparam int BPE   = 8;
    localparam int W0    = 23;
    localparam int W1    = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        cfg_en;
    logic [7:0]  cfg_len;
    logic [63:0] dat;
    logic [63:0] wt;
    logic [7:0]  dnz;
    logic [7:0]  wnz;
    logic        dv;
    logic        wv;
    logic [W0-1:0] d0;
    logic          p0;
    logic          s0;
    logic [W1-1:0] d1;
    logic          p1;
    logic          s1;

    nv_nvdla_cmac_core_macn #(.ATOMC(ATOMC), .BPE(BPE), .ACC_GUARD(4)) u_g4 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .cfg_reg_en(cfg_en), .cfg_acc_len(cfg_len),
        .dat_actv_data(dat), .dat_actv_nz(dnz), .dat_actv_pvld(dv),
        .wt_actv_data(wt), .wt_actv_nz(wnz), .wt_actv_pvld(wv),
        .mac_out_data(d0), .mac_out_pvld(p0), .mac_out_sat(s0)
    );

    nv_nvdla_cmac_core_macn #(.ATOMC(ATOMC), .BPE(BPE), .ACC_GUARD(0)) u_g0 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .cfg_reg_en(cfg_en), .cfg_acc_len(cfg_len),
        .dat_actv_data(dat), .dat_actv_nz(dnz), .dat_actv_pvld(dv),
        .wt_actv_data(wt), .wt_actv_nz(wnz), .wt_actv_pvld(wv),
        .mac_out_data(d1), .mac_out_pvld(p1), .mac_out_sat(s1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int chk_start = 1000000;

    // ---------------- model state ----------------
    typedef struct {
        int     due;
        int     inst;
        longint data;
        bit     sat;
        bit     rst;
    } exp_t;
    exp_t exp_q[$];

    int     accw [2] = '{W0, W1};
    longint macc [2];
    int     mcnt [2];
    bit     mstk [2];
    int     mlen = 1;
    longint last_d [2] = '{0, 0};
    bit     last_s [2] = '{0, 0};

    // observed DUT pulses (for literal checks)
    int               obs_cnt [2] = '{0, 0};
    logic signed [63:0] obs_d [2];
    logic             obs_s [2];
    int               obs_cyc [2];
    int               drv_cyc;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic drop_after(input int c);
        exp_t keep[$];
        foreach (exp_q[i]) if (exp_q[i].due <= c) keep.push_back(exp_q[i]);
        exp_q = keep;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            macc[k] = 0;
            mcnt[k] = 0;
            mstk[k] = 0;
        end
    endtask

    task automatic model_accept(input logic [63:0] d, input logic [63:0] w,
                                input logic [7:0] dn, input logic [7:0] wn);
        longint dot = 0;
        for (int l = 0; l < ATOMC; l++) begin
            logic signed [7:0] a;
            logic signed [7:0] b;
            a = d[l*8 +: 8];
            b = w[l*8 +: 8];
            if (dn[l] && wn[l]) dot += longint'(a) * longint'(b);
        end
        for (int k = 0; k < 2; k++) begin
            longint hi = (64'sd1 <<< (accw[k] - 1)) - 1;
            longint lo = -hi - 1;
            longint acc = (mcnt[k] == 0) ? dot : macc[k] + dot;
            exp_t e;
            if (acc > hi) begin acc = hi; mstk[k] = 1; end
            if (acc < lo) begin acc = lo; mstk[k] = 1; end
            macc[k] = acc;
            mcnt[k]++;
            if (mcnt[k] >= mlen) begin
                e.due = cyc + 3; e.inst = k; e.data = acc; e.sat = mstk[k]; e.rst = 0;
                exp_q.push_back(e);
                mcnt[k] = 0;
                mstk[k] = 0;
            end
        end
    endtask

    // ---------------- compare process ----------------
    task automatic check_inst(input int k, input logic signed [63:0] d, input logic p, input logic s);
        exp_t e;
        bit found = 0;
        exp_t keep[$];
        foreach (exp_q[i]) if (exp_q[i].due == cyc && exp_q[i].inst == k) begin
            e = exp_q[i];
            found = 1;
        end
        if (found && e.rst) begin
            chk($sformatf("rst_pvld%0d", k), {63'd0, p}, 0);
            chk($sformatf("rst_data%0d", k), d, 0);
            chk($sformatf("rst_sat%0d", k), {63'd0, s}, 0);
            last_d[k] = 0;
            last_s[k] = 0;
        end else if (found) begin
            chk($sformatf("pulse_pvld%0d", k), {63'd0, p}, 1);
            chk($sformatf("pulse_data%0d", k), d, e.data);
            chk($sformatf("pulse_sat%0d", k), {63'd0, s}, {63'd0, e.sat});
            last_d[k] = e.data;
            last_s[k] = e.sat;
        end else begin
            chk($sformatf("idle_pvld%0d", k), {63'd0, p}, 0);
            chk($sformatf("hold_data%0d", k), d, last_d[k]);
            chk($sformatf("hold_sat%0d", k), {63'd0, s}, {63'd0, last_s[k]});
        end
        if (p === 1'b1) begin
            obs_cnt[k]++;
            obs_d[k]   = d;
            obs_s[k]   = s;
            obs_cyc[k] = cyc;
        end
        foreach (exp_q[i]) if (!(exp_q[i].inst == k && exp_q[i].due <= cyc)) keep.push_back(exp_q[i]);
        exp_q = keep;
    endtask

    always @(negedge clk) begin
        if (cyc >= chk_start) begin
            check_inst(0, $signed(d0), p0, s0);
            check_inst(1, $signed(d1), p1, s1);
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [63:0] rep(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic drive(input logic [63:0] d, input logic [63:0] w,
                         input logic [7:0] dn, input logic [7:0] wn,
                         input logic vd, input logic vw,
                         input logic cfg, input logic [7:0] len);
        @(negedge clk); #1;
        rstn = 1'b1; dat = d; wt = w; dnz = dn; wnz = wn;
        dv = vd; wv = vw; cfg_en = cfg; cfg_len = len;
        drv_cyc = cyc;
        if (cfg) begin
            mlen = (len == 0) ? 1 : int'(len);
            model_clear();
            drop_after(cyc);
        end else if (vd && vw) begin
            model_accept(d, w, dn, wn);
        end
    endtask

    // non-cfg cycles carry a changing cfg_acc_len that must be ignored
    task automatic atom(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] dn, input logic [7:0] wn);
        drive(rep(a), rep(b), dn, wn, 1'b1, 1'b1, 1'b0, 8'd5);
    endtask

    task automatic cfg(input logic [7:0] len);
        drive(rep(8'h55), rep(8'h55), 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, len);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(rep(8'h7F), rep(8'h7F), 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'd2);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk); #1;
        rstn = 1'b0; dv = 1'b0; wv = 1'b0; cfg_en = 1'b0;
        mlen = 1;
        model_clear();
        drop_after(cyc);
        for (int k = 0; k < 2; k++) begin
            e.due = cyc + 1; e.inst = k; e.data = 0; e.sat = 0; e.rst = 1;
            exp_q.push_back(e);
        end
    endtask

    int base0;
    int base1;
    int t_atom;

    initial begin
        rstn = 1'b0; cfg_en = 1'b0; cfg_len = 8'd0; dat = '0; wt = '0;
        dnz = '0; wnz = '0; dv = 1'b0; wv = 1'b0;
        do_reset();
        chk_start = cyc + 1;

        // 1: len=1, all lanes 1x1 -> 8 after 3 cycles
        cfg(8'd1);
        base0 = obs_cnt[0];
        atom(8'd1, 8'd1, 8'hFF, 8'hFF);
        t_atom = drv_cyc;
        idle(5);
        chk("t1_pulses", obs_cnt[0] - base0, 1);
        chk("t1_data", obs_d[0], 8);
        chk("t1_sat", {63'd0, obs_s[0]}, 0);
        chk("t1_latency", obs_cyc[0] - t_atom, 3);

        // 2: 127x127 with half the feature lanes masked
        atom(8'd127, 8'd127, 8'h0F, 8'hFF);
        idle(4);
        chk("t2_data", obs_d[0], 64516);
        chk("t2_data_g0", obs_d[1], 64516);

        // 3a: len=4, four -128x-128 atoms back to back
        cfg(8'd4);
        base0 = obs_cnt[0];
        for (int i = 0; i < 4; i++) atom(8'h80, 8'h80, 8'hFF, 8'hFF);
        t_atom = drv_cyc;
        idle(5);
        chk("t3_pulses", obs_cnt[0] - base0, 1);
        chk("t3_data", obs_d[0], 524288);
        chk("t3_sat", {63'd0, obs_s[0]}, 0);
        chk("t3_latency", obs_cyc[0] - t_atom, 3);

        // 3b: len=2 on the guard-less instance saturates positive
        cfg(8'd2);
        for (int i = 0; i < 2; i++) atom(8'h80, 8'h80, 8'hFF, 8'hFF);
        idle(4);
        chk("t3b_data_g0", obs_d[1], 262143);
        chk("t3b_sat_g0", {63'd0, obs_s[1]}, 1);
        chk("t3b_data_g4", obs_d[0], 262144);

        // 4: cfg in the middle of a group discards it
        cfg(8'd4);
        base0 = obs_cnt[0];
        atom(8'd1, 8'd1, 8'hFF, 8'hFF);
        atom(8'd1, 8'd1, 8'hFF, 8'hFF);
        cfg(8'd4);
        for (int i = 0; i < 4; i++) atom(8'd1, 8'd1, 8'hFF, 8'hFF);
        idle(5);
        chk("t4_pulses", obs_cnt[0] - base0, 1);
        chk("t4_data", obs_d[0], 32);
        chk("t4_sat_g0", {63'd0, obs_s[1]}, 0);

        // 5: one-sided valid cycles are ignored
        cfg(8'd3);
        base0 = obs_cnt[0];
        atom(8'd2, 8'd3, 8'hFF, 8'hFF);
        drive(rep(8'd100), rep(8'd100), 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd9);
        atom(8'd2, 8'd3, 8'hFF, 8'hFF);
        drive(rep(8'd90), rep(8'd90), 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 8'd1);
        idle(1);
        atom(8'd2, 8'd3, 8'hFF, 8'hFF);
        idle(5);
        chk("t5_pulses", obs_cnt[0] - base0, 1);
        chk("t5_data", obs_d[0], 144);

        // 6: reset mid-group, then a fresh group of three
        cfg(8'd3);
        base0 = obs_cnt[0];
        atom(8'd1, 8'd1, 8'hFF, 8'hFF);
        atom(8'd1, 8'd1, 8'hFF, 8'hFF);
        idle(1);
        do_reset();
        cfg(8'd3);
        for (int i = 0; i < 3; i++) atom(8'd1, 8'd1, 8'hFF, 8'hFF);
        idle(5);
        chk("t6_pulses", obs_cnt[0] - base0, 1);
        chk("t6_data", obs_d[0], 24);

        // 7: len=0 behaves as 1; mixed signs with a sparse mask
        cfg(8'd0);
        base1 = obs_cnt[1];
        atom(8'd5, 8'hFD, 8'hAA, 8'hFF);
        atom(8'd5, 8'hFD, 8'hAA, 8'hFF);
        idle(5);
        chk("t7_pulses", obs_cnt[1] - base1, 2);
        chk("t7_data", obs_d[1], -60);

        // 8: negative saturation with len=3 on the guard-less instance
        cfg(8'd3);
        for (int i = 0; i < 3; i++) atom(8'h80, 8'h7F, 8'hFF, 8'hFF);
        idle(4);
        chk("t8_data_g0", obs_d[1], -262144);
        chk("t8_sat_g0", {63'd0, obs_s[1]}, 1);
        chk("t8_data_g4", obs_d[0], -390144);

        // 9: assorted lane patterns, len=2, model-checked back to back
        cfg(8'd2);
        drive(64'h7F80_0102_FE03_40C0, 64'h0102_7F80_C040_FF11, 8'hF3, 8'h5F, 1'b1, 1'b1, 1'b0, 8'd0);
        drive(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'd7);
        drive(64'h8080_8080_7F7F_7F7F, 64'h7F7F_7F7F_8080_8080, 8'hFF, 8'h0F, 1'b1, 1'b1, 1'b0, 8'd3);
        drive(64'h0000_FFFF_0101_A5A5, 64'h5A5A_0101_FFFF_0000, 8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0, 8'd1);
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
